// File: rtl/road_sensor_avg_multi.sv
// Multi-road moving-average block for the signal-timing controller.
// Each road keeps a running sum over its last 2**WIN_LOG2 vehicle-count samples,
// held in one shared ring RAM. A sample costs three cycles: IDLE accepts it,
// RD fetches the oldest slot of that road, and UPD swaps old for new in the sum.
// The published average follows one cycle later, together with its strobe.
module road_sensor_avg_multi #(
   parameter int NUM_ROADS = 4,
   parameter int SEL_W     = 2,
   parameter int DATA_W    = 8,
   parameter int WIN_LOG2  = 6,
   parameter int INIT_VAL  = 20
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [SEL_W-1:0]              next_road,
   input  logic                          sample_stb,
   input  logic [DATA_W-1:0]             data_in,
   output logic                          busy,
   output logic                          drop,
   output logic [NUM_ROADS*DATA_W-1:0]   avg_flat,
   output logic [NUM_ROADS-1:0]          avg_upd
);

   localparam int DEPTH     = 2 ** WIN_LOG2;
   localparam int SUM_W     = DATA_W + WIN_LOG2;
   localparam int ADDR_W    = SEL_W + WIN_LOG2;
   localparam int INIT_LAST = NUM_ROADS * DEPTH - 1;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_UPD} state_t;

   state_t              r_state;
   logic                r_busy;
   logic                r_drop;
   logic [SEL_W-1:0]    r_road;
   logic [DATA_W-1:0]   r_data;
   logic [ADDR_W-1:0]   r_init_cnt;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_pend;
   logic [SEL_W-1:0]    r_pend_road;

   // Ring storage is addressed {road, slot}; the init counter walks the same
   // layout, so road-major order falls out of a plain binary count.
   logic [DATA_W-1:0]   r_ring [2**ADDR_W];

   logic [NUM_ROADS*WIN_LOG2-1:0] w_wptr_all;
   logic [WIN_LOG2-1:0]           w_cur_wptr;
   logic                          w_we;
   logic [ADDR_W-1:0]             w_waddr;
   logic [DATA_W-1:0]             w_wdata;
   logic [ADDR_W-1:0]             w_raddr;
   logic                          w_road_ok;

   // Write pointer of the road currently being processed.
   always_comb begin
      w_cur_wptr = '0;
      for (int r = 0; r < NUM_ROADS; r++) begin
         if (r_road == SEL_W'(r))
            w_cur_wptr = w_wptr_all[r*WIN_LOG2 +: WIN_LOG2];
      end
   end

   // Out-of-range road numbers are filtered before they can reach the RAM.
   assign w_road_ok = ({1'b0, next_road} < (SEL_W+1)'(NUM_ROADS));
   assign w_raddr   = {r_road, w_cur_wptr};
   assign w_we      = !reset && ((r_state == S_INIT) || (r_state == S_UPD));
   assign w_waddr   = (r_state == S_INIT) ? r_init_cnt : {r_road, w_cur_wptr};
   assign w_wdata   = (r_state == S_INIT) ? DATA_W'(INIT_VAL) : r_data;

   // Control FSM: init sweep, accept, read oldest, update; busy/drop registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_INIT;
         r_busy      <= 1'b1;
         r_drop      <= 1'b0;
         r_init_cnt  <= '0;
         r_road      <= '0;
         r_data      <= '0;
         r_pend      <= 1'b0;
         r_pend_road <= '0;
      end else begin
         r_drop <= sample_stb && r_busy;
         r_pend <= 1'b0;
         case (r_state)
            S_INIT: begin
               if (r_init_cnt == ADDR_W'(INIT_LAST)) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_init_cnt <= r_init_cnt + ADDR_W'(1);
               end
            end
            S_IDLE: begin
               if (sample_stb && w_road_ok) begin
                  r_road  <= next_road;
                  r_data  <= data_in;
                  r_state <= S_RD;
                  r_busy  <= 1'b1;
               end
            end
            S_RD: begin
               r_state <= S_UPD;
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_pend      <= 1'b1;
               r_pend_road <= r_road;
            end
         endcase
      end
   end

   // Ring RAM with registered read; the read only happens in RD, writes in INIT/UPD.
   always_ff @(posedge clk) begin
      if (w_we)
         r_ring[w_waddr] <= w_wdata;
      if (r_state == S_RD)
         r_rd_data <= r_ring[w_raddr];
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ROADS; gi++) begin : g_road
         logic [SUM_W-1:0]    r_sum;
         logic [WIN_LOG2-1:0] r_wptr;
         logic [DATA_W-1:0]   r_avg;
         logic                r_upd;

         // Per-road sum/pointer swap in UPD, then publish floor(sum/depth) one cycle later.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_sum  <= SUM_W'(INIT_VAL * DEPTH);
               r_wptr <= '0;
               r_avg  <= DATA_W'(INIT_VAL);
               r_upd  <= 1'b0;
            end else begin
               r_upd <= r_pend && (r_pend_road == SEL_W'(gi));
               if ((r_state == S_UPD) && (r_road == SEL_W'(gi))) begin
                  r_sum  <= r_sum - SUM_W'(r_rd_data) + SUM_W'(r_data);
                  r_wptr <= r_wptr + WIN_LOG2'(1);
               end
               if (r_pend && (r_pend_road == SEL_W'(gi)))
                  r_avg <= r_sum[SUM_W-1:WIN_LOG2];
            end
         end

         assign w_wptr_all[gi*WIN_LOG2 +: WIN_LOG2] = r_wptr;
         assign avg_flat[gi*DATA_W +: DATA_W]       = r_avg;
         assign avg_upd[gi]                         = r_upd;
      end
   endgenerate

   assign busy = r_busy;
   assign drop = r_drop;

endmodule

// File: tb/tb_road_sensor_avg_multi.sv
// Directed bench for road_sensor_avg_multi (4 roads, 3-bit select, 64-deep window).
module tb_road_sensor_avg_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  next_road;
   logic        sample_stb;
   logic [7:0]  data_in;
   logic        busy;
   logic        drop;
   logic [31:0] avg_flat;
   logic [3:0]  avg_upd;

   int total = 0;
   int bad   = 0;
   int exp_avg [4];

   road_sensor_avg_multi #(
      .NUM_ROADS(4), .SEL_W(3), .DATA_W(8), .WIN_LOG2(6), .INIT_VAL(20)
   ) dut (
      .clk(clk), .reset(reset), .next_road(next_road), .sample_stb(sample_stb),
      .data_in(data_in), .busy(busy), .drop(drop), .avg_flat(avg_flat), .avg_upd(avg_upd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_flat();
      logic [31:0] f;
      for (int r = 0; r < 4; r++) f[r*8 +: 8] = exp_avg[r][7:0];
      return f;
   endfunction

   // Count cycles until busy falls (bounded).
   task automatic count_init(input string tag);
      int n;
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      chk(tag, n, 256);
   endtask

   // Present one sample and check latency, strobe and averages.
   task automatic send(input int road, input int data, input int exp_val, input string tag);
      int n;
      n = 0;
      while (busy && n < 10) begin
         tick();
         n++;
      end
      sample_stb = 1'b1;
      next_road  = 3'(road);
      data_in    = 8'(data);
      tick();                       // edge N: accepted
      sample_stb = 1'b0;
      tick();                       // N+1
      tick();                       // N+2
      chk({tag, "_upd_early"}, {28'd0, avg_upd}, 32'd0);
      tick();                       // N+3
      exp_avg[road] = exp_val;
      chk({tag, "_upd"}, {28'd0, avg_upd}, 32'd1 << road);
      chk({tag, "_avg"}, avg_flat, exp_flat());
      $display("sample road=%0d data=%0d avg_flat=%08h upd=%b", road, data, avg_flat, avg_upd);
   endtask

   initial begin
      for (int r = 0; r < 4; r++) exp_avg[r] = 20;
      reset = 1'b1; sample_stb = 1'b0; next_road = '0; data_in = '0;

      // 1: reset state and init sweep length
      tick();
      reset = 1'b0;
      chk("rst_avg",  avg_flat, 32'h14141414);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_drop", {31'd0, drop}, 32'd0);
      chk("rst_upd",  {28'd0, avg_upd}, 32'd0);
      count_init("init_len");

      // 2: road 1 fed 84 sixty-four times -> 21..84
      for (int k = 1; k <= 64; k++) send(1, 84, 20 + k, "r1");

      // 3: road 2 drained to 0, then 255 -> 3 (wraps the pointer)
      for (int k = 1; k <= 64; k++) send(2, 0, (1280 - 20 * k) / 64, "r2z");
      send(2, 255, 3, "r2_255");

      // 4: back-to-back strobes: first accepted, next two dropped
      sample_stb = 1'b1; next_road = 3'd0; data_in = 8'd100;
      tick();                                   // N accept
      tick();                                   // N+1
      chk("drop1", {31'd0, drop}, 32'd1);
      tick();                                   // N+2
      chk("drop2", {31'd0, drop}, 32'd1);
      sample_stb = 1'b0;
      tick();                                   // N+3
      exp_avg[0] = 21;                          // (1280-20+100)>>6
      chk("drop_end", {31'd0, drop}, 32'd0);
      chk("b2b_upd", {28'd0, avg_upd}, 32'd1);
      chk("b2b_avg", avg_flat, exp_flat());
      tick();
      chk("b2b_idle", {31'd0, busy}, 32'd0);
      chk("b2b_noupd", {28'd0, avg_upd}, 32'd0);
      $display("b2b avg_flat=%08h", avg_flat);

      // 5: out-of-range road ignored
      sample_stb = 1'b1; next_road = 3'd7; data_in = 8'd200;
      tick();
      chk("bad_busy", {31'd0, busy}, 32'd0);
      chk("bad_drop", {31'd0, drop}, 32'd0);
      sample_stb = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("bad_upd", {28'd0, avg_upd}, 32'd0);
      chk("bad_avg", avg_flat, exp_flat());
      $display("road7 avg_flat=%08h", avg_flat);

      // 6: reset during UPD discards the update and restarts init
      sample_stb = 1'b1; next_road = 3'd3; data_in = 8'd200;
      tick();                                   // N accept
      sample_stb = 1'b0;
      tick();                                   // N+1, now in UPD
      reset = 1'b1;
      tick();                                   // N+2 under reset
      reset = 1'b0;
      for (int r = 0; r < 4; r++) exp_avg[r] = 20;
      chk("rst2_avg",  avg_flat, 32'h14141414);
      chk("rst2_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("rst2_noupd", {28'd0, avg_upd}, 32'd0);
      chk("rst2_avg2",  avg_flat, 32'h14141414);
      begin
         int n;
         n = 1;
         while (busy && n < 400) begin
            tick();
            n++;
         end
         chk("init2_len", n, 256);
      end
      send(3, 84, 21, "r3_after_rst");
      send(1, 20, 20, "r1_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
